uart_rx_fifo: RTL and testbench

Parametrised UART receiver, the next generation of the peripheral-bus receiver. Adds run-time baud divisor, configurable data width, optional even/odd parity, 1 or 2 stop bits, 16x oversampling with 3-sample majority vote and false-start rejection. Also adds break detection and a receive FIFO with valid/ready pop handshake and per-entry error flags. It sits between the pad-side `i_rx` and the UART register block, which pops bytes and reads status.

---
 rtl/uart_rx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver with majority vote, break detect and receive FIFO
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic [DIV_W-1:0]              i_div,
  input  logic                          i_parity_en,
  input  logic                          i_parity_odd,
  input  logic                          i_stop2,
  input  logic                          i_rx,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_perr,
  output logic                          o_ferr,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overrun,
  input  logic                          i_clr_err,
  output logic                          o_break,
  output logic                          o_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic s1, s2, s3;
  logic [DIV_W-1:0] tcnt;
  logic [3:0] sub;
  logic [2:0] bcnt;
  logic v7, v8, pbit, stop1;
  logic [DATA_W-1:0] shreg;
  logic tick, s9, s15, maj, fall, last, fstop, ferr, perr, is_break, push, pop, full, wr;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  assign fall     = s3 & ~s2;
  assign tick     = (state != IDLE) && (tcnt >= i_div);
  assign s9       = tick && sub == 4'd9;
  assign s15      = tick && sub == 4'd15;
  assign maj      = (v7 & v8) | (v7 & s2) | (v8 & s2);
  assign last     = state == STOP && s9 && (!i_stop2 || bcnt[0]);
  assign fstop    = i_stop2 ? stop1 : maj;
  assign ferr     = ~maj | (i_stop2 & ~stop1);
  assign perr     = i_parity_en & ((^shreg ^ pbit) != i_parity_odd);
  assign is_break = last && shreg == '0 && !(i_parity_en && pbit) && !fstop;
  assign push     = last && !is_break;
  assign o_valid  = o_level != '0;
  assign pop      = o_valid & i_ready;
  assign full     = o_level == (AW+1)'(FIFO_DEPTH);
  assign wr       = push & (~full | pop);
  assign o_busy   = state != IDLE;
  assign {o_ferr, o_perr, o_data} = o_valid ? mem[rp] : '0;
  // frame state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end
  // frame sequencing: start qualification, data, optional parity, stop bits
  always_comb begin
    state_n = state;
    if (!i_en) state_n = IDLE;
    else case (state)
      IDLE:    state_n = fall ? START : IDLE;
      START:   state_n = (s9 && maj) ? IDLE : s15 ? DATA : START;
      DATA:    state_n = (s15 && bcnt == 3'(DATA_W-1)) ? (i_parity_en ? PARITY : STOP) : DATA;
      PARITY:  state_n = s15 ? STOP : PARITY;
      STOP:    state_n = last ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // synchroniser, oversample counters, vote samples and shift register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      {s1, s2, s3} <= 3'b111;
      tcnt <= '0;
      sub <= '0;
      bcnt <= '0;
      {v7, v8, pbit, stop1} <= '0;
      shreg <= '0;
    end else begin
      s1 <= i_rx;
      s2 <= s1;
      s3 <= s2;
      if (state == IDLE || state_n == IDLE) begin
        tcnt <= '0;
        sub <= '0;
        bcnt <= '0;
      end else begin
        tcnt <= tick ? '0 : tcnt + 1'b1;
        if (tick) sub <= sub + 1'b1;
        if (tick && sub == 4'd7) v7 <= s2;
        if (tick && sub == 4'd8) v8 <= s2;
        if (s9 && state == DATA) shreg <= {maj, shreg[DATA_W-1:1]};
        if (s9 && state == PARITY) pbit <= maj;
        if (s9 && state == STOP) stop1 <= maj;
        if (s15 && state == DATA) bcnt <= bcnt == 3'(DATA_W-1) ? 3'd0 : bcnt + 1'b1;
        if (s15 && state == STOP) bcnt <= 3'd1;
      end
    end
  end
  // FIFO pointers, level, sticky overrun and break pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wp <= '0;
      rp <= '0;
      o_level <= '0;
      o_overrun <= 1'b0;
      o_break <= 1'b0;
    end else begin
      o_break <= is_break;
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      o_level <= o_level + (AW+1)'(wr) - (AW+1)'(pop);
      o_overrun <= (push & full & ~pop) | (o_overrun & ~i_clr_err);
    end
  end
  // FIFO storage of {ferr, perr, data}
  always_ff @(posedge i_clk) begin
    if (wr) mem[wp] <= {ferr, perr, shreg};
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo with directed serial frames
module tb_uart_rx_fifo;
  localparam int BP = 64;
  logic clk = 0, rst = 0, en = 1, par_en = 0, par_odd = 0, stop2 = 0, rx = 1, ready = 1, clr = 0;
  logic [15:0] div = 16'd3;
  logic [7:0] data;
  logic perr, ferr, valid, overrun, brk, busy;
  logic [2:0] level;
  logic [9:0] q[$];
  logic [9:0] exp_e;
  int total = 0, bad = 0, brk_cnt = 0;

  uart_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_div(div), .i_parity_en(par_en),
    .i_parity_odd(par_odd), .i_stop2(stop2), .i_rx(rx), .o_data(data), .o_perr(perr),
    .o_ferr(ferr), .o_valid(valid), .i_ready(ready), .o_level(level), .o_overrun(overrun),
    .i_clr_err(clr), .o_break(brk), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // monitor: compare every popped head entry against the scoreboard
  always @(negedge clk) begin
    if (brk) brk_cnt++;
    if (valid && ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got=%h", {ferr, perr, data});
      end else begin
        exp_e = q.pop_front();
        if ({ferr, perr, data} !== exp_e) begin
          bad++;
          $display("FAIL pop_entry got={ferr,perr,data}=%h exp=%h", {ferr, perr, data}, exp_e);
        end
      end
    end
  end

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    wait_clk(BP);
  endtask

  task automatic send(input logic [7:0] d, input logic pb, input logic s2b);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (par_en) bit_out(pb);
    bit_out(1'b1);
    if (stop2) bit_out(s2b);
  endtask

  task automatic expect_e(input logic [7:0] d, input logic p, input logic f);
    q.push_back({f, p, d});
  endtask

  task automatic drain(input string n);
    for (int i = 0; i < 3000 && q.size() != 0; i++) wait_clk(1);
    check({n, "_drained"}, q.size(), 0);
    wait_clk(2);
    check({n, "_level0"}, level, 0);
  endtask

  initial begin
    #2 rst = 1;
    wait_clk(3);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_perr", perr, 0);
    check("rst_ferr", ferr, 0);
    check("rst_level", level, 0);
    check("rst_overrun", overrun, 0);
    check("rst_break", brk, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    wait_clk(BP);

    expect_e(8'hA5, 0, 0);
    expect_e(8'h3C, 0, 0);
    send(8'hA5, 0, 1);
    send(8'h3C, 0, 1);
    bit_out(1'b1);
    drain("b2b");

    par_en = 1;
    par_odd = 0;
    expect_e(8'h07, 1, 0);
    send(8'h07, 0, 1);
    expect_e(8'h07, 0, 0);
    send(8'h07, 1, 1);
    bit_out(1'b1);
    drain("parity");

    par_en = 0;
    stop2 = 1;
    expect_e(8'h55, 0, 1);
    send(8'h55, 0, 0);
    rx = 1;
    wait_clk(BP);
    expect_e(8'h55, 0, 0);
    send(8'h55, 0, 1);
    bit_out(1'b1);
    drain("stop2");

    rx = 0;
    wait_clk(1);
    rx = 1;
    wait_clk(68);
    check("glitch_busy", busy, 0);
    check("glitch_level", level, 0);
    stop2 = 0;

    check("pre_break_cnt", brk_cnt, 0);
    rx = 0;
    wait_clk(12 * BP);
    rx = 1;
    wait_clk(2 * BP);
    check("break_pulse", brk_cnt, 1);
    check("break_level", level, 0);
    expect_e(8'h81, 0, 0);
    send(8'h81, 0, 1);
    bit_out(1'b1);
    drain("after_break");

    ready = 0;
    expect_e(8'h11, 0, 0);
    expect_e(8'h22, 0, 0);
    expect_e(8'h33, 0, 0);
    expect_e(8'h44, 0, 0);
    send(8'h11, 0, 1);
    send(8'h22, 0, 1);
    send(8'h33, 0, 1);
    send(8'h44, 0, 1);
    check("full_no_ovr", overrun, 0);
    send(8'h55, 0, 1);
    bit_out(1'b1);
    check("full_level", level, 4);
    check("overrun_set", overrun, 1);
    clr = 1;
    wait_clk(1);
    clr = 0;
    check("overrun_clr", overrun, 0);
    ready = 1;
    drain("overrun");

    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    rst = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_level", level, 0);
    wait_clk(2);
    rst = 0;
    wait_clk(BP);
    expect_e(8'h12, 0, 0);
    send(8'h12, 0, 1);
    bit_out(1'b1);
    drain("after_rst");

    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    en = 0;
    wait_clk(3);
    check("en_off_busy", busy, 0);
    en = 1;
    wait_clk(2 * BP);
    check("en_off_level", level, 0);
    expect_e(8'h34, 0, 0);
    send(8'h34, 0, 1);
    bit_out(1'b1);
    drain("after_en");
    check("final_break_cnt", brk_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
